// File: rtl/heartbeat_pkg.sv
// rtl/heartbeat_pkg.sv - shared types and helpers for the heartbeat interval meter
package heartbeat_pkg;

    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TIMEOUT = 2'd2
    } hb_state_e;

    // Clock cycles per millisecond, never below one.
    function automatic int ms_divisor(input int clk_hz);
        return (clk_hz / 1000 < 1) ? 1 : clk_hz / 1000;
    endfunction

endpackage

// File: rtl/heartbeat_interval_meter_ms_tick_gen.sv
// rtl/heartbeat_interval_meter_ms_tick_gen.sv - millisecond prescaler with synchronous clear
module ms_tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk_clk,
    input  logic reset_reset,
    input  logic clear,
    output logic ms_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || cnt_q == TERM) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ms_tick = (cnt_q == TERM);

endmodule

// File: rtl/heartbeat_interval_meter.sv
// rtl/heartbeat_interval_meter.sv - beat-to-beat interval meter with artefact rejection and timeout
module heartbeat_interval_meter
    import heartbeat_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int MIN_IBI_MS  = 250,
    parameter int MAX_IBI_MS  = 2000,
    parameter int DATA_W      = DATA_W_DEFAULT
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              pulse_in,
    output logic [DATA_W-1:0] heartbeat_data_export,
    output logic              beat_valid,
    output logic              timeout,
    output logic [7:0]        artefact_count
);

    localparam logic [DATA_W-1:0] MIN_L = DATA_W'(MIN_IBI_MS);
    localparam logic [DATA_W-1:0] MAX_L = DATA_W'(MAX_IBI_MS);

    hb_state_e         state_q;
    logic              sync1_q, sync2_q, edge_q;
    logic [DATA_W-1:0] ms_cnt_q, ms_cnt_d;
    logic [DATA_W-1:0] data_q;
    logic              beat_valid_q, timeout_q;
    logic [7:0]        art_q;

    logic              rise, ms_tick;
    logic [DATA_W-1:0] meas;
    logic              too_early, too_late, artefact_hit, restart;

    assign rise = sync2_q & ~edge_q;

    // The tick landing on the closing edge belongs to the interval that just ended.
    assign meas = (ms_tick && ms_cnt_q != '1) ? ms_cnt_q + 1'b1 : ms_cnt_q;

    assign too_early    = (meas < MIN_L);
    assign too_late     = (meas > MAX_L);
    assign artefact_hit = rise && (state_q == MEASURE) && too_early;
    assign restart      = rise && !artefact_hit;

    always_comb begin
        ms_cnt_d = meas;
        if (restart) begin
            ms_cnt_d = '0;
        end
    end

    ms_tick_gen #(
        .DIV(ms_divisor(CLK_FREQ_HZ))
    ) u_tick (
        .clk_clk    (clk_clk),
        .reset_reset(reset_reset),
        .clear      (restart),
        .ms_tick    (ms_tick)
    );

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            edge_q   <= 1'b0;
            ms_cnt_q <= '0;
        end else begin
            sync1_q  <= pulse_in;
            sync2_q  <= sync1_q;
            edge_q   <= sync2_q;
            ms_cnt_q <= ms_cnt_d;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q      <= IDLE;
            data_q       <= '0;
            beat_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            art_q        <= '0;
        end else begin
            beat_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= MEASURE;
                    end
                end
                MEASURE: begin
                    // A late rise only restarts timing; it reports nothing.
                    if (rise) begin
                        if (too_early) begin
                            if (art_q != 8'hFF) begin
                                art_q <= art_q + 8'd1;
                            end
                        end else if (!too_late) begin
                            data_q       <= meas;
                            beat_valid_q <= 1'b1;
                        end
                    end else if (too_late) begin
                        state_q   <= TIMEOUT;
                        timeout_q <= 1'b1;
                    end
                end
                TIMEOUT: begin
                    if (rise) begin
                        state_q   <= MEASURE;
                        timeout_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign heartbeat_data_export = data_q;
    assign beat_valid            = beat_valid_q;
    assign timeout               = timeout_q;
    assign artefact_count        = art_q;

endmodule

// File: tb/tb_heartbeat_interval_meter.sv
// tb/tb_heartbeat_interval_meter.sv - scoreboard bench for heartbeat_interval_meter
module tb_heartbeat_interval_meter;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic        pulse_in;
    logic [15:0] heartbeat_data_export;
    logic        beat_valid;
    logic        timeout;
    logic [7:0]  artefact_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int exp_data_q[$];
    int exp_cyc_q[$];

    heartbeat_interval_meter #(
        .CLK_FREQ_HZ(10_000),
        .MIN_IBI_MS (250),
        .MAX_IBI_MS (2000),
        .DATA_W     (16)
    ) dut (
        .clk_clk              (clk_clk),
        .reset_reset          (reset_reset),
        .pulse_in             (pulse_in),
        .heartbeat_data_export(heartbeat_data_export),
        .beat_valid           (beat_valid),
        .timeout              (timeout),
        .artefact_count       (artefact_count)
    );

    always #5 clk_clk = ~clk_clk;

    always @(posedge clk_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every beat_valid must match the oldest expected beat.
    always @(negedge clk_clk) begin
        if (!reset_reset && beat_valid) begin
            if (exp_data_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: data %0d at cycle %0d, none expected",
                         heartbeat_data_export, cyc);
            end else begin
                chk("beat_data", int'(heartbeat_data_export), exp_data_q.pop_front());
                chk("beat_cycle", cyc, exp_cyc_q.pop_front());
            end
        end
    end

    task automatic at(input int t);
        while (cyc < t) @(negedge clk_clk);
    endtask

    task automatic beat(input int t, input int width, input bit exp_v, input int exp_data);
        at(t);
        pulse_in = 1'b1;
        if (exp_v) begin
            exp_data_q.push_back(exp_data);
            exp_cyc_q.push_back(cyc + 3);
        end
        repeat (width) @(negedge clk_clk);
        pulse_in = 1'b0;
    endtask

    task automatic spike(input int t);
        at(t);
        pulse_in = 1'b1;
        repeat (2) @(negedge clk_clk);
        pulse_in = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"}, int'(heartbeat_data_export), 0);
        chk({tag, "_valid"}, int'(beat_valid), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
        chk({tag, "_artefacts"}, int'(artefact_count), 0);
    endtask

    initial begin
        int t0, t1, r2, r3, r4, a, b, c, d;
        reset_reset = 1'b1;
        pulse_in    = 1'b0;
        repeat (3) @(negedge clk_clk);
        reset_reset = 1'b0;
        chk_zero("por");

        // Reset in the middle of a measurement.
        t0 = cyc + 10;
        beat(t0, 20, 1'b0, 0);
        beat(t0 + 3000, 20, 1'b1, 300);
        spike(t0 + 3500);
        at(t0 + 4000);
        chk("pre_reset_artefacts", int'(artefact_count), 1);
        chk("pre_reset_data", int'(heartbeat_data_export), 300);
        reset_reset = 1'b1;
        repeat (2) @(negedge clk_clk);
        reset_reset = 1'b0;
        chk_zero("mid_reset");

        // Nominal 800 ms beats, artefacts and saturation inside the windows.
        t1 = cyc + 50;
        r2 = t1 + 8000;
        r3 = t1 + 16000;
        r4 = t1 + 24000;
        beat(t1, 20, 1'b0, 0);
        beat(r2, 20, 1'b1, 800);
        spike(r2 + 1000);
        at(r2 + 1100);
        chk("spike_100ms", int'(artefact_count), 1);
        spike(r2 + 2490);
        at(r2 + 2600);
        chk("spike_249ms", int'(artefact_count), 2);
        beat(r3, 20, 1'b1, 800);
        for (int i = 0; i < 300; i++) spike(r3 + 20 + 4 * i);
        at(r3 + 1300);
        chk("artefact_sat", int'(artefact_count), 255);
        beat(r4, 20, 1'b1, 800);

        // 250 ms and 2000 ms boundaries; the 2000 ms beat is then held high.
        a = r4 + 2500;
        b = a + 20000;
        beat(a, 20, 1'b1, 250);
        at(b);
        pulse_in = 1'b1;
        exp_data_q.push_back(2000);
        exp_cyc_q.push_back(cyc + 3);
        at(b + 20005);
        chk("timeout_before", int'(timeout), 0);
        at(b + 20015);
        chk("timeout_after", int'(timeout), 1);
        chk("timeout_data_held", int'(heartbeat_data_export), 2000);
        at(b + 21000);
        chk("held_high_timeout", int'(timeout), 1);
        pulse_in = 1'b0;

        // Recovery from timeout.
        c = b + 21100;
        d = c + 10000;
        beat(c, 20, 1'b0, 0);
        at(c + 30);
        chk("timeout_cleared", int'(timeout), 0);
        chk("recover_data_held", int'(heartbeat_data_export), 2000);
        beat(d, 20, 1'b1, 1000);

        for (int i = 0; i < 40 && exp_data_q.size() != 0; i++) @(negedge clk_clk);
        chk("scoreboard_drained", exp_data_q.size(), 0);
        chk("final_data", int'(heartbeat_data_export), 1000);
        chk("final_artefacts", int'(artefact_count), 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
